// File: rtl/ex_hazard_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : ex_hazard_ctrl_if
// Purpose  : Bundle between the ID/EX pipeline datapath and the execute-stage
//            hazard/forwarding scheduler. The master is the pipeline (drives
//            ID-stage decode info and the MEM redirect); the slave is the
//            scheduler (drives stall/bubble/flush and operand forward selects).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ex_hazard_ctrl_if #(
  parameter int AW = 5
);
  // ID-stage instruction description
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic          id_uses_rt;
  logic [AW-1:0] id_rw;
  logic          id_regwr;
  logic          id_memtoreg;
  // MEM-stage taken branch / jump
  logic          mem_redirect;
  // Pipeline controls
  logic          pc_stall;
  logic          ifid_stall;
  logic          idex_bubble;
  logic          ifid_flush;
  logic          exmem_flush;
  // EX operand mux selects: 00 BusA/BusB, 01 EX/MEM ALUout, 10 WB data
  logic [1:0]    fwd_a;
  logic [1:0]    fwd_b;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_rw, id_regwr, id_memtoreg, mem_redirect,
    input  pc_stall, ifid_stall, idex_bubble, ifid_flush, exmem_flush, fwd_a, fwd_b
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_rw, id_regwr, id_memtoreg, mem_redirect,
    output pc_stall, ifid_stall, idex_bubble, ifid_flush, exmem_flush, fwd_a, fwd_b
  );
endinterface

`default_nettype wire

// File: rtl/ex_hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module   : ex_hazard_ctrl
// Purpose  : Execute-stage hazard and forwarding scheduler for a 5-stage
//            pipeline. Shadows rw/regwr/memtoreg of the EX, MEM and WB
//            instructions and derives stall, bubble and flush controls plus
//            registered EX operand forward selects. Branches resolve in MEM,
//            so a redirect squashes IF/ID, ID/EX and EX/MEM.
// Config   : HAZARD_FWD_EN defined   -> forwarding enabled, only load-use stalls.
//            HAZARD_FWD_EN undefined -> no forwarding (fwd = 00), every RAW
//                                       dependency still in flight stalls.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ex_hazard_ctrl #(
  parameter int AW        = 5,
  parameter bit WB_BYPASS = 1'b1
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  ex_hazard_ctrl_if.slave   hz,
  output logic [1:0]        dbg_state_o,
  output logic              dbg_ex_wr_o
);

  typedef struct packed {
    logic [AW-1:0] rw;
    logic          wr;
    logic          m2r;
  } shadow_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  shadow_t ex_q, mem_q, wb_q;
  shadow_t ex_d, mem_d;
  state_t  state_q, state_d;

  logic w_hazard;
  logic w_pc_stall;
  logic w_ifid_stall;
  logic w_idex_bubble;
  logic w_ifid_flush;
  logic w_exmem_flush;

  // Register 0 is hard-wired zero, so it can never be a producer.
  function automatic logic match(input shadow_t s, input logic [AW-1:0] r);
    return s.wr && (s.rw == r) && (r != '0);
  endfunction

`ifdef HAZARD_FWD_EN
  logic [1:0] fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;

  // Youngest producer wins; a load still in EX has no data yet (that is the stall cycle).
  function automatic logic [1:0] fwd_sel(input shadow_t ex_s, input shadow_t mem_s,
                                         input shadow_t wb_s, input logic [AW-1:0] r);
    if (match(ex_s, r) && !ex_s.m2r)                return 2'b01;
    else if (match(mem_s, r))                       return 2'b10;
    else if ((WB_BYPASS == 1'b0) && match(wb_s, r)) return 2'b10;
    else                                            return 2'b00;
  endfunction

  // With forwarding, only a load directly ahead of its consumer must wait.
  assign w_hazard = ex_q.m2r &&
                    (match(ex_q, hz.id_rs) || (hz.id_uses_rt && match(ex_q, hz.id_rt)));

  // Select for the instruction entering EX; a bubble entering EX never forwards.
  always_comb begin
    fwd_a_d = 2'b00;
    fwd_b_d = 2'b00;
    if (!w_idex_bubble) begin
      fwd_a_d = fwd_sel(ex_q, mem_q, wb_q, hz.id_rs);
      fwd_b_d = fwd_sel(ex_q, mem_q, wb_q, hz.id_rt);
    end
  end

  // Forward selects are registered so they line up with the operands in EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign hz.fwd_a = fwd_a_q;
  assign hz.fwd_b = fwd_b_q;
`else
  logic w_hz_rs, w_hz_rt;

  // Without forwarding, any in-flight producer not yet visible to the regfile read stalls.
  assign w_hz_rs = match(ex_q, hz.id_rs) || match(mem_q, hz.id_rs) ||
                   ((WB_BYPASS == 1'b0) && match(wb_q, hz.id_rs));
  assign w_hz_rt = match(ex_q, hz.id_rt) || match(mem_q, hz.id_rt) ||
                   ((WB_BYPASS == 1'b0) && match(wb_q, hz.id_rt));
  assign w_hazard = w_hz_rs || (hz.id_uses_rt && w_hz_rt);

  assign hz.fwd_a = 2'b00;
  assign hz.fwd_b = 2'b00;
`endif

  // Some shadow bits are carried only for visibility in one configuration.
  logic w_unused;
  assign w_unused = ^{ex_q.m2r, mem_q.m2r, wb_q};

  // Next state and pipeline controls; a redirect overrides any stall this cycle.
  always_comb begin
    state_d       = state_q;
    w_pc_stall    = 1'b0;
    w_ifid_stall  = 1'b0;
    w_idex_bubble = 1'b0;
    w_ifid_flush  = 1'b0;
    w_exmem_flush = 1'b0;

    if (hz.mem_redirect) begin
      w_ifid_flush  = 1'b1;
      w_idex_bubble = 1'b1;
      w_exmem_flush = 1'b1;
    end else if (w_hazard) begin
      w_pc_stall    = 1'b1;
      w_ifid_stall  = 1'b1;
      w_idex_bubble = 1'b1;
    end

    case (state_q)
      ST_RUN: begin
        if (hz.mem_redirect)  state_d = ST_FLUSH;
        else if (w_hazard)    state_d = ST_STALL;
      end
      ST_STALL: begin
        if (hz.mem_redirect)  state_d = ST_FLUSH;
        else if (!w_hazard)   state_d = ST_RUN;
      end
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Shadow next values: bubbles and flushes turn the slot into a non-writing NOP.
  always_comb begin
    ex_d  = w_idex_bubble ? '0 : '{rw: hz.id_rw, wr: hz.id_regwr, m2r: hz.id_memtoreg};
    mem_d = w_exmem_flush ? '0 : ex_q;
  end

  // Shadow pipeline and FSM state advance every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      state_q <= ST_RUN;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= mem_q;
      state_q <= state_d;
    end
  end

  // Controls are forced low while reset is asserted, independent of inputs.
  assign hz.pc_stall    = rst_n & w_pc_stall;
  assign hz.ifid_stall  = rst_n & w_ifid_stall;
  assign hz.idex_bubble = rst_n & w_idex_bubble;
  assign hz.ifid_flush  = rst_n & w_ifid_flush;
  assign hz.exmem_flush = rst_n & w_exmem_flush;

  assign dbg_state_o = state_q;
  assign dbg_ex_wr_o = ex_q.wr;

endmodule

`default_nettype wire

// File: tb/tb_ex_hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_ex_hazard_ctrl
// Purpose  : Scoreboard bench for ex_hazard_ctrl. Instance A uses WB_BYPASS=1,
//            instance B uses WB_BYPASS=0 and is compared only where noted.
//            Expectations follow HAZARD_FWD_EN when it is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ex_hazard_ctrl;

  localparam logic [4:0] C0  = 5'b00000;  // {pc_stall,ifid_stall,idex_bubble,ifid_flush,exmem_flush}
  localparam logic [4:0] CS  = 5'b11100;
  localparam logic [4:0] CF  = 5'b00111;
  localparam logic [1:0] RUN = 2'd0;
  localparam logic [1:0] STL = 2'd1;
  localparam logic [1:0] FLU = 2'd2;

  typedef struct {
    string      nm;
    logic [4:0] ctl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [1:0] st;
    logic       cb;   // compare instance B pc_stall
    logic       bv;
    logic       ce;   // compare EX shadow write flag
    logic       ev;
  } exp_t;

  logic clk;
  logic rst_n;
  logic rst_next;
  logic [1:0] st_a, st_b;
  logic       exwr_a, exwr_b;
  exp_t       sb_q[$];
  int         checks;
  int         errors;

  ex_hazard_ctrl_if #(.AW(5)) if_a ();
  ex_hazard_ctrl_if #(.AW(5)) if_b ();

  ex_hazard_ctrl #(.AW(5), .WB_BYPASS(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .hz(if_a), .dbg_state_o(st_a), .dbg_ex_wr_o(exwr_a)
  );

  ex_hazard_ctrl #(.AW(5), .WB_BYPASS(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .hz(if_b), .dbg_state_o(st_b), .dbg_ex_wr_o(exwr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One ID-stage cycle: drive both instances, queue the expected response.
  task automatic cyc(input string nm, input logic [4:0] rs, input logic [4:0] rt,
                     input logic ut, input logic [4:0] rw, input logic wr,
                     input logic m2r, input logic red, input logic [4:0] ctl,
                     input logic [1:0] fa, input logic [1:0] fb, input logic [1:0] st,
                     input logic cb, input logic bv, input logic ce, input logic ev);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst_next;
    if_a.id_rs = rs; if_a.id_rt = rt; if_a.id_uses_rt = ut; if_a.id_rw = rw;
    if_a.id_regwr = wr; if_a.id_memtoreg = m2r; if_a.mem_redirect = red;
    if_b.id_rs = rs; if_b.id_rt = rt; if_b.id_uses_rt = ut; if_b.id_rw = rw;
    if_b.id_regwr = wr; if_b.id_memtoreg = m2r; if_b.mem_redirect = red;
    e.nm = nm; e.ctl = ctl; e.fa = fa; e.fb = fb; e.st = st;
    e.cb = cb; e.bv = bv; e.ce = ce; e.ev = ev;
    sb_q.push_back(e);
  endtask

  task automatic nop(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                     input logic [1:0] st);
    cyc(nm, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C0, fa, fb, st, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every cycle with a queued expectation, compare on the falling edge.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      logic [4:0] act;
      logic       bad;
      e   = sb_q.pop_front();
      act = {if_a.pc_stall, if_a.ifid_stall, if_a.idex_bubble, if_a.ifid_flush, if_a.exmem_flush};
      bad = (act !== e.ctl) || (if_a.fwd_a !== e.fa) || (if_a.fwd_b !== e.fb) || (st_a !== e.st) ||
            (e.cb && (if_b.pc_stall !== e.bv)) || (e.ce && (exwr_a !== e.ev));
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s: got ctl=%b fwd_a=%b fwd_b=%b state=%0d b_stall=%b ex_wr=%b; expected ctl=%b fwd_a=%b fwd_b=%b state=%0d b_stall=%b(chk %b) ex_wr=%b(chk %b)",
                 e.nm, act, if_a.fwd_a, if_a.fwd_b, st_a, if_b.pc_stall, exwr_a,
                 e.ctl, e.fa, e.fb, e.st, e.bv, e.cb, e.ev, e.ce);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    rst_next = 1'b0;
    if_a.id_rs = '0; if_a.id_rt = '0; if_a.id_uses_rt = 1'b0; if_a.id_rw = '0;
    if_a.id_regwr = 1'b0; if_a.id_memtoreg = 1'b0; if_a.mem_redirect = 1'b0;
    if_b.id_rs = '0; if_b.id_rt = '0; if_b.id_uses_rt = 1'b0; if_b.id_rw = '0;
    if_b.id_regwr = 1'b0; if_b.id_memtoreg = 1'b0; if_b.mem_redirect = 1'b0;

    // Reset: outputs low even with a would-be redirect applied.
    cyc("rst_idle", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C0, 2'b00, 2'b00, RUN, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc("rst_redir", 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, C0, 2'b00, 2'b00, RUN, 1'b1, 1'b0, 1'b1, 1'b0);
    rst_next = 1'b1;

    // Register 0 producer followed by a $0 consumer: never a dependency.
    cyc("r0_prod", 5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, C0, 2'b00, 2'b00, RUN, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("r0_use",  5'd0, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, C0, 2'b00, 2'b00, RUN, 1'b0, 1'b0, 1'b0, 1'b0);
    nop("r0_fwd", 2'b00, 2'b00, RUN);

`ifndef HAZARD_FWD_EN
    // RAW without forwarding: 2 stalls with WB bypass (A), 3 without (B).
    cyc("raw_prod", 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, C0, 2'b00, 2'b00, RUN, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("raw_use1", 5'd3, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, CS, 2'b00, 2'b00, RUN, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("raw_use2", 5'd3, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, CS, 2'b00, 2'b00, STL, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("raw_use3", 5'd3, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, C0, 2'b00, 2'b00, STL, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("raw_done", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C0, 2'b00, 2'b00, RUN, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
    nop("drain1", 2'b00, 2'b00, RUN);
    nop("drain2", 2'b00, 2'b00, RUN);

    // Load-use hazard coincident with a redirect: redirect wins, then one FLUSH cycle.
    cyc("lu_lw",    5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, C0, 2'b00, 2'b00, RUN, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("lu_redir", 5'd5, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1, CF, 2'b00, 2'b00, RUN, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("flush_st", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C0, 2'b00, 2'b00, FLU, 1'b0, 1'b0, 1'b1, 1'b0);
    nop("flush_run", 2'b00, 2'b00, RUN);

`ifdef HAZARD_FWD_EN
    // lw $5; add $6,$5,$1 -> one stall, then fwd_a=10.
    cyc("f1_lw",   5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, C0, 2'b00, 2'b00, RUN, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("f1_stall", 5'd5, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, CS, 2'b00, 2'b00, RUN, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("f1_issue", 5'd5, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, C0, 2'b00, 2'b00, STL, 1'b0, 1'b0, 1'b0, 1'b0);
    nop("f1_fwd", 2'b10, 2'b00, RUN);
    // add $3; sub $4,$3,$2 -> fwd_a=01, no stall.
    cyc("f2_add", 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, C0, 2'b00, 2'b00, RUN, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("f2_sub", 5'd3, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, C0, 2'b00, 2'b00, RUN, 1'b0, 1'b0, 1'b0, 1'b0);
    nop("f2_fwd", 2'b01, 2'b00, RUN);
    // add $3; nop; or $7,$1,$3 -> fwd_b=10, fwd_a=00, no stall.
    cyc("f3_add", 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, C0, 2'b00, 2'b00, RUN, 1'b0, 1'b0, 1'b0, 1'b0);
    nop("f3_nop", 2'b00, 2'b00, RUN);
    cyc("f3_or",  5'd1, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, C0, 2'b00, 2'b00, RUN, 1'b0, 1'b0, 1'b0, 1'b0);
    nop("f3_fwd", 2'b00, 2'b10, RUN);
    nop("f3_clr", 2'b00, 2'b00, RUN);
`endif

    // Reset asserted in a STALL cycle: outputs drop at once, no stall after release.
    cyc("rs_lw",    5'd1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, C0, 2'b00, 2'b00, RUN, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("rs_stall", 5'd7, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, CS, 2'b00, 2'b00, RUN, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_next = 1'b0;
    cyc("rs_assert", 5'd7, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, C0, 2'b00, 2'b00, RUN, 1'b1, 1'b0, 1'b1, 1'b0);
    rst_next = 1'b1;
    cyc("rs_release", 5'd7, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, C0, 2'b00, 2'b00, RUN, 1'b0, 1'b0, 1'b1, 1'b0);
    nop("rs_after", 2'b00, 2'b00, RUN);

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
